// File: rtl/bram_axis_line_reader.sv
// bram_axis_line_reader: fetches BRAM lines over an index range and streams their words on AXI-Stream.
// A current/next line buffer pair hides read latency so consecutive lines stream without bubbles.
module bram_axis_line_reader #(
  parameter int BRAM_DEPTH     = 12,
  parameter int WORD_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 36,
  parameter int RD_LATENCY     = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [BRAM_DEPTH-1:0]                start_index,
  input  logic [BRAM_DEPTH-1:0]                bound_index,
  output logic                                 bram_en,
  output logic [BRAM_DEPTH-1:0]                bram_addr,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_rdata,
  output logic [WORD_WIDTH-1:0]                m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 busy,
  output logic                                 done
);
  localparam int LW = WORD_WIDTH * WORDS_PER_LINE;
  localparam int CW = $clog2(WORDS_PER_LINE);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, STREAM} state_t;
  state_t                r_state, w_next;
  logic [BRAM_DEPTH-1:0] r_addr, r_left, r_bram_addr;
  logic [RD_LATENCY-1:0] r_pipe;
  logic [LW-1:0]         r_cur, r_nxt;
  logic [CW-1:0]         r_word;
  logic                  r_nxt_v, r_last, r_first, r_bram_en, r_done;
  logic                  w_ret, w_hs, w_eol, w_valid, w_busy;
  assign w_ret = r_pipe[RD_LATENCY-1];
  assign w_eol = r_word == CW'(WORDS_PER_LINE - 1);
  assign w_hs  = w_valid & m_axis_tready;
  always_ff @(posedge clk)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   w_next = WAIT;
      WAIT:    if (w_ret) w_next = STREAM;
      STREAM:  if (w_hs && w_eol && r_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_valid = r_state == STREAM;
    w_busy  = r_state != IDLE;
  end
  // r_left counts lines still to be fetched after the one most recently issued
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_left      <= '0;
      r_bram_addr <= '0;
      r_bram_en   <= 1'b0;
      r_pipe      <= '0;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_nxt_v     <= 1'b0;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_first     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_bram_en <= 1'b0;
      r_done    <= 1'b0;
      r_pipe    <= RD_LATENCY'({r_pipe, r_bram_en});
      if (r_state == IDLE && start) begin
        r_addr  <= start_index;
        r_left  <= bound_index - start_index;
        r_nxt_v <= 1'b0;
        r_word  <= '0;
      end
      if (r_state == FETCH) begin
        r_bram_en   <= 1'b1;
        r_bram_addr <= r_addr;
        r_addr      <= r_addr + 1'b1;
      end
      if (r_state == WAIT && w_ret) begin
        r_cur   <= bram_rdata;
        r_last  <= r_left == '0;
        r_first <= 1'b1;
      end
      if (r_state == STREAM) begin
        r_first <= 1'b0;
        if (r_first && r_left != '0) begin
          r_bram_en   <= 1'b1;
          r_bram_addr <= r_addr;
          r_addr      <= r_addr + 1'b1;
          r_left      <= r_left - 1'b1;
        end
        if (w_ret) begin
          r_nxt   <= bram_rdata;
          r_nxt_v <= 1'b1;
        end
        if (w_hs) begin
          r_word <= w_eol ? '0 : r_word + 1'b1;
          if (w_eol && r_last) r_done <= 1'b1;
          // a prefetch landing on the swap edge bypasses the next buffer
          if (w_eol && !r_last) begin
            r_cur   <= r_nxt_v ? r_nxt : bram_rdata;
            r_nxt_v <= 1'b0;
            r_last  <= r_left == '0;
            r_first <= 1'b1;
          end
        end
      end
    end
  end
  assign bram_en       = r_bram_en;
  assign bram_addr     = r_bram_addr;
  assign m_axis_tdata  = r_cur[WORD_WIDTH*int'(r_word) +: WORD_WIDTH];
  assign m_axis_tvalid = w_valid;
  assign m_axis_tlast  = w_valid & r_last & w_eol;
  assign busy          = w_busy;
  assign done          = r_done;
endmodule

// File: tb/tb_bram_axis_line_reader.sv
// tb_bram_axis_line_reader: scoreboard bench with a 2-cycle BRAM model and directed ranges.
module tb_bram_axis_line_reader;
  localparam int D = 12, W = 16, N = 36, LW = W * N;
  logic          clk = 0, rstn = 0, start = 0, tready = 1, bp = 0;
  logic [D-1:0]  start_index = '0, bound_index = '0;
  logic          bram_en, tvalid, tlast, busy, done;
  logic [D-1:0]  bram_addr;
  logic [LW-1:0] rdata = '0, p1 = '0;
  logic [W-1:0]  tdata;
  int            checks = 0, failures = 0, cyc = 0, beats = 0, t0 = 0;
  logic [W:0]    eq[$];
  logic [D-1:0]  aq[$];
  bit            prev_en = 0, stall_prev = 0, pl = 0;
  logic [W-1:0]  pd = '0;

  bram_axis_line_reader #(.BRAM_DEPTH(D), .WORD_WIDTH(W), .WORDS_PER_LINE(N), .RD_LATENCY(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_index(start_index), .bound_index(bound_index),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(rdata),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] word_of(input logic [D-1:0] a, input int k);
    return W'(int'(a) * 131 + k * 7 + 3);
  endfunction
  function automatic logic [LW-1:0] mk_line(input logic [D-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < N; k++) l[k*W +: W] = word_of(a, k);
    return l;
  endfunction

  // BRAM model: enable sampled at an edge, data visible two edges later; idle cycles give junk
  always @(posedge clk) begin
    p1    <= bram_en ? mk_line(bram_addr) : {LW{1'b1}};
    rdata <= p1;
  end

  initial forever begin
    @(posedge clk); #1;
    tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      prev_en = 0; stall_prev = 0;
    end else begin
      if (bram_en) begin
        checks++;
        if (prev_en) begin failures++; $display("FAIL en_back_to_back got=1 want=0"); end
        checks++;
        if (aq.size() == 0) begin failures++; $display("FAIL addr_unexpected got=%0d want=none", bram_addr); end
        else begin
          logic [D-1:0] ea;
          ea = aq.pop_front();
          if (bram_addr !== ea) begin failures++; $display("FAIL addr got=%0d want=%0d", bram_addr, ea); end
        end
      end
      if (stall_prev) begin
        checks++;
        if (!tvalid || tdata !== pd || tlast !== pl) begin
          failures++; $display("FAIL stall_stable got=%b/%h/%b want=1/%h/%b", tvalid, tdata, tlast, pd, pl);
        end
      end
      if (tvalid && tready) begin
        beats++; checks++;
        if (eq.size() == 0) begin failures++; $display("FAIL beat_unexpected got=%h", tdata); end
        else begin
          logic [W:0] e;
          e = eq.pop_front();
          if ({tlast, tdata} !== e) begin
            failures++; $display("FAIL beat%0d got=%b/%h want=%b/%h", beats, tlast, tdata, e[W], e[W-1:0]);
          end
        end
      end
      stall_prev = tvalid && !tready; pd = tdata; pl = tlast; prev_en = bram_en;
    end
  end

  task automatic push_exp(input logic [D-1:0] s, input logic [D-1:0] b);
    logic [D-1:0] n, a;
    n = b - s;
    for (int i = 0; i <= int'(n); i++) begin
      a = s + D'(i);
      aq.push_back(a);
      for (int k = 0; k < N; k++) eq.push_back({i == int'(n) && k == N - 1, word_of(a, k)});
    end
  endtask

  task automatic kick(input logic [D-1:0] s, input logic [D-1:0] b);
    @(posedge clk); #1;
    start = 1; start_index = s; bound_index = b;
    @(posedge clk); #1;
    start = 0; t0 = cyc;
  endtask

  task automatic wait_done(input int nb, input bit gap, input bit lat);
    int fe = -1, fv = -1;
    bit got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (bram_en && fe < 0) fe = cyc;
      if (tvalid && fv < 0) fv = cyc;
      if (done) got = 1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL done_timeout got=0 want=1"); return; end
    if (lat) begin
      checks++;
      if (fe != t0 + 1) begin failures++; $display("FAIL en_latency got=%0d want=%0d", fe - t0, 1); end
      checks++;
      if (fv != t0 + 4) begin failures++; $display("FAIL valid_latency got=%0d want=%0d", fv - t0, 4); end
    end
    if (gap) begin
      checks++;
      if (cyc - fv != nb) begin failures++; $display("FAIL stream_span got=%0d want=%0d", cyc - fv, nb); end
    end
    checks++;
    if (busy || tvalid) begin failures++; $display("FAIL idle_at_done got=%b%b want=00", busy, tvalid); end
    checks++;
    if (eq.size() != 0 || aq.size() != 0) begin
      failures++; $display("FAIL leftover got=%0d/%0d want=0/0", eq.size(), aq.size());
    end
    @(negedge clk);
    checks++;
    if (done) begin failures++; $display("FAIL done_pulse got=1 want=0"); end
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bram_en, bram_addr, tdata, tvalid, tlast, busy, done} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", {bram_en, bram_addr, tdata, tvalid, tlast, busy, done});
    end
    @(posedge clk); #1 rstn = 1;

    push_exp(5, 5);       kick(5, 5);       wait_done(36, 1, 1);
    push_exp(10, 12);     kick(10, 12);     wait_done(108, 1, 1);
    bp = 1;
    push_exp(200, 201);   kick(200, 201);   wait_done(72, 0, 1);
    bp = 0;
    push_exp(4094, 1);    kick(4094, 1);    wait_done(144, 1, 1);

    push_exp(20, 21);     kick(20, 21);
    repeat (10) @(posedge clk);
    #1 start = 1; start_index = 100; bound_index = 100;
    @(posedge clk); #1 start = 0;
    wait_done(72, 0, 0);

    base = beats;
    push_exp(30, 31);     kick(30, 31);
    for (int i = 0; i < 500 && beats < base + 20; i++) @(negedge clk);
    @(posedge clk); #1 rstn = 0;
    @(posedge clk); #1 rstn = 1;
    @(negedge clk);
    checks++;
    if ({bram_en, bram_addr, tdata, tvalid, tlast, busy, done} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%h want=0", {bram_en, bram_addr, tdata, tvalid, tlast, busy, done});
    end
    eq.delete(); aq.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (tvalid || bram_en || busy) begin failures++; $display("FAIL post_reset_quiet got=%b%b%b want=000", tvalid, bram_en, busy); end
    push_exp(40, 40);     kick(40, 40);     wait_done(36, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_axis_line_reader.md
Name: bram_axis_line_reader

Overview:
Read-side companion to the AXIS-to-BRAM write controller. It fetches wide BRAM lines over a caller-given index range and unpacks each line into WORDS_PER_LINE words. It emits the words on an AXI-Stream master with full tvalid/tready handshake and asserts tlast on the final word. A two-line buffer (current plus prefetch) hides BRAM read latency, so consecutive lines stream with no bubble.

Parameters:
BRAM_DEPTH, 12, BRAM address width; line index range is 0..2^BRAM_DEPTH-1.
WORD_WIDTH, 16, width of one stream word in bits.
WORDS_PER_LINE, 36, number of words packed in one BRAM line (must be >= RD_LATENCY+2).
RD_LATENCY, 2, cycles from a bram_en pulse to valid bram_rdata.

Ports:
clk  in  1  clock; all logic on the rising edge.
rstn  in  1  synchronous active-low reset.
start  in  1  one-cycle request to begin a transfer; ignored while busy=1.
start_index  in  BRAM_DEPTH  first line index, sampled when start is accepted.
bound_index  in  BRAM_DEPTH  last line index (inclusive), sampled when start is accepted.
bram_en  out  1  read enable, one-cycle pulse per line.
bram_addr  out  BRAM_DEPTH  line index; valid while bram_en=1.
bram_rdata  in  WORD_WIDTH*WORDS_PER_LINE  line data, valid RD_LATENCY cycles after bram_en.
m_axis_tdata  out  WORD_WIDTH  stream word.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
m_axis_tlast  out  1  high on the last word of bound_index line.
busy  out  1  high from start acceptance until the last handshake.
done  out  1  one-cycle pulse in the cycle after the final tlast handshake.

Behaviour:
- Reset (rstn=0 at a clock edge): bram_en, bram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy and done all go to 0. Both buffers are invalidated and the FSM goes to IDLE.
- Reset asserted mid-transfer aborts immediately. Pending BRAM returns are discarded. No partial tlast is emitted.
- FSM states:
  - IDLE: start=1 latches the indices, goes to FETCH, busy=1.
  - FETCH: one-cycle bram_en pulse at the current line address, then go to WAIT.
  - WAIT: count RD_LATENCY cycles, capture bram_rdata into the current buffer, go to STREAM.
  - STREAM: emit words; go to IDLE after the tlast handshake.
- Latency: start sampled at edge T gives bram_en=1 in cycle T+1 and the first m_axis_tvalid=1 in cycle T+2+RD_LATENCY.
- Line count is ((bound_index - start_index) mod 2^BRAM_DEPTH) + 1. The line address increments modulo 2^BRAM_DEPTH, so bound < start wraps through 0. start_index == bound_index transfers exactly one line.
- Word order: word k = line bits [(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH]; k = 0 is emitted first.
- A word counter 0..WORDS_PER_LINE-1 advances only on handshake (tvalid & tready), and wraps to 0 at the end of a line.
- tdata and tlast stay stable while tvalid=1 and tready=0. tvalid never drops without a handshake.
- Prefetch: in the first STREAM cycle of each line, if more lines remain, issue bram_en for the next address. RD_LATENCY cycles later, capture into the next buffer.
- On the handshake of word WORDS_PER_LINE-1, if the next buffer is valid, copy it to the current buffer. The next cycle presents word 0 of the new line with no bubble. The parameter constraint guarantees the prefetch is always ready in time.
- bram_en is never high in two consecutive cycles. At most one read is outstanding.
- tlast=1 only on word WORDS_PER_LINE-1 of the final line.
- After the tlast handshake: tvalid=0, busy=0, done=1 for one cycle, FSM returns to IDLE. A start in that same done cycle is accepted.

Test Plan:
- Single line: start_index=bound_index=5, tready=1 → one bram_en at addr 5; 36 beats carrying words 0..35 in order. First tvalid at T+4; tlast on beat 36 only; done at the following cycle; busy low after.
- Three lines (10..12), tready=1 → bram_en at addrs 10, 11, 12; 108 contiguous beats with no tvalid gap after the first beat; tlast only on beat 108.
- Backpressure: 2 lines, tready toggled pseudo-randomly (about 50%) → tdata and tlast held stable under stall; 72 beats; sequence matches the model exactly.
- Wrap: start=4094, bound=1 → bram_addr sequence 4094, 4095, 0, 1; 144 beats; tlast on beat 144.
- Start while busy: second start with different indices during STREAM → ignored; the original range completes unchanged.
- Reset mid-line: rstn=0 for one cycle at beat 20 of line 1 → all outputs 0 on the next cycle. A new start afterwards streams correctly from word 0.
